// File: rtl/fwd_hazard_if.sv
// Decode-side bundle for fwd_hazard_unit: decode operands and stall/bypass results.
// FWD_PERF_CNT_EN adds the load-use stall counter to the bundle.
interface fwd_hazard_if #(
    parameter int REG_BITS  = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                         id_valid;
    logic [NUM_SRC*REG_BITS-1:0]  id_rs;
    logic [NUM_SRC-1:0]           id_rs_used;
    logic [REG_BITS-1:0]          id_rd;
    logic                         id_reg_write;
    logic                         id_is_load;
    logic                         mem_busy;
    logic                         flush;
    logic [NUM_SRC*SEL_W-1:0]     sel_mux;
    logic                         stall_id;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]                  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               mem_busy, flush,
        input  sel_mux, stall_id, stall_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               mem_busy, flush,
        output sel_mux, stall_id, stall_cnt
    );
`else
    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               mem_busy, flush,
        input  sel_mux, stall_id
    );
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               mem_busy, flush,
        output sel_mux, stall_id
    );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation from a shadow pipeline of destination tags.
// Optional FWD_PERF_CNT_EN: 32-bit wrapping counter of load-use stall cycles.
module fwd_hazard_unit #(
    parameter int REG_BITS   = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fwd_hazard_if.slave   bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    // stg index k = instructions k stages ahead of decode; 1 is the one now in EX
    logic                stg_valid [1:FWD_DEPTH];
    logic [REG_BITS-1:0] stg_rd    [1:FWD_DEPTH];
    logic                stg_load  [1:FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_next;
    logic [NUM_SRC*SEL_W-1:0] sel_q;
    logic [NUM_SRC-1:0]       near_ld;
    logic                     hazard;
    logic                     accept;

    // Scan from the oldest stage toward EX so the nearest producer overwrites last.
    always_comb begin
        sel_next = '0;
        near_ld  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (bus.id_rs_used[i] &&
                    (bus.id_rs[i*REG_BITS +: REG_BITS] != '0) &&
                    stg_valid[k] &&
                    (stg_rd[k] == bus.id_rs[i*REG_BITS +: REG_BITS])) begin
                    sel_next[i*SEL_W +: SEL_W] = SEL_W'(k);
                    near_ld[i] = stg_load[k] && (k < LOAD_READY);
                end
            end
        end
    end

    assign hazard       = |near_ld;
    assign accept       = bus.id_valid && !hazard && !bus.flush;
    assign bus.stall_id = bus.mem_busy || (bus.id_valid && hazard && !bus.flush);
    assign bus.sel_mux  = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                stg_valid[k] <= 1'b0;
                stg_rd[k]    <= '0;
                stg_load[k]  <= 1'b0;
            end
            sel_q <= '0;
        end else if (!bus.mem_busy) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_rd[k]    <= stg_rd[k-1];
                stg_load[k]  <= stg_load[k-1];
            end
            stg_valid[1] <= accept && bus.id_reg_write;
            stg_rd[1]    <= bus.id_rd;
            stg_load[1]  <= bus.id_is_load;
            sel_q        <= accept ? sel_next : '0;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!bus.mem_busy && bus.id_valid && hazard && !bus.flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default build (depth 2, ready 2) and a depth 4 / ready 3 instance.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_BITS(5), .NUM_SRC(2), .FWD_DEPTH(2)) ia ();
    fwd_hazard_if #(.REG_BITS(5), .NUM_SRC(2), .FWD_DEPTH(4)) ib ();

    fwd_hazard_unit #(.REG_BITS(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_READY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave)
    );
    fwd_hazard_unit #(.REG_BITS(5), .NUM_SRC(2), .FWD_DEPTH(4), .LOAD_READY(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(ib.slave)
    );

    task automatic drive_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                           input logic [1:0] used, input logic [4:0] rd,
                           input logic wr, input logic ld);
        ia.id_valid     = v;
        ia.id_rs        = {rs1, rs0};
        ia.id_rs_used   = used;
        ia.id_rd        = rd;
        ia.id_reg_write = wr;
        ia.id_is_load   = ld;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs0, input logic [1:0] used,
                           input logic [4:0] rd, input logic wr, input logic ld);
        ib.id_valid     = v;
        ib.id_rs        = {5'd0, rs0};
        ib.id_rs_used   = used;
        ib.id_rd        = rd;
        ib.id_reg_write = wr;
        ib.id_is_load   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        drive_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL reset_sel: got %0h expected 0", ia.sel_mux);
        end
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %0b expected 0", ia.stall_id);
        end
        ia.mem_busy = 1'b1;
        #1;
        checks++;
        if (ia.stall_id !== 1'b1) begin
            errors++; $display("FAIL reset_stall_busy: got %0b expected 1", ia.stall_id);
        end
        ia.mem_busy = 1'b0;
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ia.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", ia.stall_cnt);
        end
`endif
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        tick();
    endtask

    task automatic test_fwd_stage1();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd5, 2'b01, 5'd6, 1'b0, 1'b0);
        #1;
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL s1_stall: got %0b expected 0", ia.stall_id);
        end
        tick();
        checks++;
        if (ia.sel_mux !== 4'b0001) begin
            errors++; $display("FAIL s1_sel: got %0h expected 1", ia.sel_mux);
        end
        drain_a();
    endtask

    task automatic test_fwd_stage2();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b0, 1'b0);
        tick();
        checks++;
        if (ia.sel_mux !== 4'b1000) begin
            errors++; $display("FAIL s2_sel: got %0h expected 8", ia.sel_mux);
        end
        drain_a();
    endtask

    task automatic test_nearest();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b0, 1'b0);
        tick();
        checks++;
        if (ia.sel_mux !== 4'b0101) begin
            errors++; $display("FAIL nearest_sel: got %0h expected 5", ia.sel_mux);
        end
        drain_a();
    endtask

    task automatic test_x0_unused();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b01, 5'd6, 1'b0, 1'b0);
        #1;
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got %0b expected 0", ia.stall_id);
        end
        tick();
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL x0_sel: got %0h expected 0", ia.sel_mux);
        end
        drain_a();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd5, 5'd5, 2'b00, 5'd6, 1'b0, 1'b0);
        #1;
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL unused_stall: got %0b expected 0", ia.stall_id);
        end
        tick();
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL unused_sel: got %0h expected 0", ia.sel_mux);
        end
        drain_a();
    endtask

    task automatic test_load_use();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd0, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0);
        #1;
        checks++;
        if (ia.stall_id !== 1'b1) begin
            errors++; $display("FAIL lu_stall1: got %0b expected 1", ia.stall_id);
        end
        tick();
        exp_cnt++;
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL lu_stall2: got %0b expected 0", ia.stall_id);
        end
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL lu_bubble_sel: got %0h expected 0", ia.sel_mux);
        end
        tick();
        checks++;
        if (ia.sel_mux !== 4'b0010) begin
            errors++; $display("FAIL lu_sel: got %0h expected 2", ia.sel_mux);
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ia.stall_cnt !== 32'(exp_cnt)) begin
            errors++; $display("FAIL lu_cnt: got %0d expected %0d", ia.stall_cnt, exp_cnt);
        end
`endif
        drain_a();
    endtask

    task automatic test_mem_busy();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd4, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd0, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0);
        ia.mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ia.stall_id !== 1'b1) begin
                errors++; $display("FAIL busy_stall[%0d]: got %0b expected 1", c, ia.stall_id);
            end
            tick();
            checks++;
            if (ia.sel_mux !== 4'b0001) begin
                errors++; $display("FAIL busy_sel[%0d]: got %0h expected 1", c, ia.sel_mux);
            end
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ia.stall_cnt !== 32'(exp_cnt)) begin
            errors++; $display("FAIL busy_cnt: got %0d expected %0d", ia.stall_cnt, exp_cnt);
        end
`endif
        ia.mem_busy = 1'b0;
        #1;
        checks++;
        if (ia.stall_id !== 1'b1) begin
            errors++; $display("FAIL busy_lu_stall: got %0b expected 1", ia.stall_id);
        end
        tick();
        exp_cnt++;
        checks++;
        if (ia.stall_id !== 1'b0 || ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL busy_lu_bubble: got stall %0b sel %0h expected 0 0",
                               ia.stall_id, ia.sel_mux);
        end
        tick();
        checks++;
        if (ia.sel_mux !== 4'b0010) begin
            errors++; $display("FAIL busy_lu_sel: got %0h expected 2", ia.sel_mux);
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ia.stall_cnt !== 32'(exp_cnt)) begin
            errors++; $display("FAIL busy_cnt2: got %0d expected %0d", ia.stall_cnt, exp_cnt);
        end
`endif
        drain_a();
    endtask

    task automatic test_flush();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd0, 5'd7, 2'b01, 5'd5, 1'b1, 1'b0);
        ia.flush = 1'b1;
        #1;
        checks++;
        if (ia.stall_id !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %0b expected 0", ia.stall_id);
        end
        tick();
        ia.flush = 1'b0;
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL flush_sel: got %0h expected 0", ia.sel_mux);
        end
        drive_a(1'b1, 5'd0, 5'd5, 2'b01, 5'd6, 1'b0, 1'b0);
        tick();
        checks++;
        if (ia.sel_mux !== 4'd0) begin
            errors++; $display("FAIL flush_killed_write: got %0h expected 0", ia.sel_mux);
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ia.stall_cnt !== 32'(exp_cnt)) begin
            errors++; $display("FAIL flush_cnt: got %0d expected %0d", ia.stall_cnt, exp_cnt);
        end
`endif
        drain_a();
    endtask

    task automatic test_deep_load_use();
        drive_b(1'b1, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        drive_b(1'b1, 5'd9, 2'b01, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (ib.stall_id !== 1'b1) begin
            errors++; $display("FAIL deep_stall1: got %0b expected 1", ib.stall_id);
        end
        tick();
        checks++;
        if (ib.stall_id !== 1'b1 || ib.sel_mux !== 6'd0) begin
            errors++; $display("FAIL deep_stall2: got stall %0b sel %0h expected 1 0",
                               ib.stall_id, ib.sel_mux);
        end
        tick();
        checks++;
        if (ib.stall_id !== 1'b0) begin
            errors++; $display("FAIL deep_stall3: got %0b expected 0", ib.stall_id);
        end
        tick();
        checks++;
        if (ib.sel_mux !== 6'b000011) begin
            errors++; $display("FAIL deep_sel: got %0h expected 3", ib.sel_mux);
        end
        drive_b(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_b(1'b1, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        drive_b(1'b1, 5'd9, 2'b01, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (ib.stall_id !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got %0b expected 1", ib.stall_id);
        end
        rst_n_b = 1'b0;
        #1;
        checks++;
        if (ib.stall_id !== 1'b0 || ib.sel_mux !== 6'd0) begin
            errors++; $display("FAIL rst_mid_out: got stall %0b sel %0h expected 0 0",
                               ib.stall_id, ib.sel_mux);
        end
        tick();
        rst_n_b = 1'b1;
        #1;
        checks++;
        if (ib.stall_id !== 1'b0) begin
            errors++; $display("FAIL rst_mid_empty: got %0b expected 0", ib.stall_id);
        end
        tick();
        checks++;
        if (ib.sel_mux !== 6'd0) begin
            errors++; $display("FAIL rst_mid_sel: got %0h expected 0", ib.sel_mux);
        end
    endtask

    initial begin
        drive_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        drive_b(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        ia.mem_busy = 1'b0;
        ia.flush    = 1'b0;
        ib.mem_busy = 1'b0;
        ib.flush    = 1'b0;
        tick();
        test_reset();
        test_fwd_stage1();
        test_fwd_stage2();
        test_nearest();
        test_x0_unused();
        test_load_use();
        test_mem_busy();
        test_flush();
        test_deep_load_use();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
